// File: rtl/f_add_sub_if.sv
// f_add_sub_if: operand/result bundle for the registered adder/subtractor
interface f_add_sub_if #(parameter int WIDTH = 4);
  logic             valid_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             control_in;
  logic [WIDTH-1:0] sum_out;
  logic             carry_out;
  logic             overflow_out;
  logic             zero_out;
  logic             valid_out;
  modport master (
    output valid_in, a_in, b_in, control_in,
    input  sum_out, carry_out, overflow_out, zero_out, valid_out
  );
  modport slave (
    input  valid_in, a_in, b_in, control_in,
    output sum_out, carry_out, overflow_out, zero_out, valid_out
  );
endinterface

// File: rtl/f_add_sub.sv
// f_add_sub: registered ripple-carry two's-complement adder/subtractor with carry, overflow and zero flags
module f_add_sub #(
  parameter int WIDTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  f_add_sub_if.slave bus
);
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;
  // subtraction is a + ~b + 1: invert B and inject the +1 as carry-in
  assign bx   = bus.b_in ^ {WIDTH{bus.control_in}};
  assign c[0] = bus.control_in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = bus.a_in[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (bus.a_in[i] & bx[i]) | (c[i] & (bus.a_in[i] ^ bx[i]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum_out      <= '0;
      bus.carry_out    <= 1'b0;
      bus.overflow_out <= 1'b0;
      bus.zero_out     <= 1'b0;
      bus.valid_out    <= 1'b0;
    end else begin
      bus.valid_out <= bus.valid_in;
      if (bus.valid_in) begin
        bus.sum_out      <= s;
        bus.carry_out    <= c[WIDTH];
        bus.overflow_out <= c[WIDTH] ^ c[WIDTH-1];
        bus.zero_out     <= ~|s;
      end
    end
  end
endmodule

// File: tb/tb_f_add_sub.sv
// tb_f_add_sub: directed and exhaustive checks of the registered adder/subtractor
module tb_f_add_sub;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  f_add_sub_if #(.WIDTH(W)) bus ();
  f_add_sub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [W-1:0] es, input logic ec, input logic ev, input logic ez, input logic evo);
    chk({tag, ".sum"}, 32'(bus.sum_out), 32'(es));
    chk({tag, ".carry"}, 32'(bus.carry_out), 32'(ec));
    chk({tag, ".ovf"}, 32'(bus.overflow_out), 32'(ev));
    chk({tag, ".zero"}, 32'(bus.zero_out), 32'(ez));
    chk({tag, ".vout"}, 32'(bus.valid_out), 32'(evo));
  endtask
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic ctl);
    bus.valid_in   = v;
    bus.a_in       = a;
    bus.b_in       = b;
    bus.control_in = ctl;
  endtask
  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic ctl,
                    input logic [W-1:0] es, input logic ec, input logic ev, input logic ez);
    @(negedge clk);
    drive(1'b1, a, b, ctl);
    @(posedge clk);
    #1;
    chk_all(tag, es, ec, ev, ez, 1'b1);
  endtask
  initial begin
    logic [W:0] r;
    logic [W-1:0] ea, eb;
    logic ectl, eovf;
    drive(1'b1, 4'd7, 4'd14, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("7+14", 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    op("0+0",   4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b1);
    op("1+8",   4'd1,  4'd8,  1'b0, 4'd9,  1'b0, 1'b0, 1'b0);
    op("3+12",  4'd3,  4'd12, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0);
    op("7+1",   4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1, 1'b0);
    op("15-15", 4'd15, 4'd15, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1);
    op("1-1",   4'd1,  4'd1,  1'b1, 4'd0,  1'b1, 1'b0, 1'b1);
    op("1-2",   4'd1,  4'd2,  1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    op("1-4",   4'd1,  4'd4,  1'b1, 4'd13, 1'b0, 1'b0, 1'b0);
    op("1-8",   4'd1,  4'd8,  1'b1, 4'd9,  1'b0, 1'b1, 1'b0);
    op("3-12",  4'd3,  4'd12, 1'b1, 4'd7,  1'b0, 1'b0, 1'b0);
    op("7-14",  4'd7,  4'd14, 1'b1, 4'd9,  1'b0, 1'b1, 1'b0);
    op("1+1",   4'd1,  4'd1,  1'b0, 4'd2,  1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'd15, 4'd15, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_all("hold", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    op("1+8_pre", 4'd1, 4'd8, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'd3, 4'd12, 1'b0);
    @(posedge clk);
    #1;
    chk_all("post_rst", 4'd15, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 512; k++) begin
      ea   = W'(k);
      eb   = W'(k >> 4);
      ectl = k[8];
      r    = ectl ? {1'b0, ea} - {1'b0, eb} : {1'b0, ea} + {1'b0, eb};
      eovf = ectl ? (ea[3] != eb[3]) && (r[3] != ea[3]) : (ea[3] == eb[3]) && (r[3] != ea[3]);
      op($sformatf("ex%0d", k), ea, eb, ectl, r[W-1:0], ectl ? (ea >= eb) : r[W], eovf, r[W-1:0] == 0);
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/f_add_sub.md
# f_add_sub

Registered, parameterised two's-complement adder/subtractor built from a ripple chain of full-adder cells. A single control bit selects A+B or A−B. Results and status flags are registered, one clock after the operands are accepted. It is a leaf arithmetic block feeding datapath logic that needs sum, carry/borrow and signed-overflow status.

## Interface
- WIDTH, 4, operand and result width in bits (≥ 2)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- valid_in  input  1  operands and control are sampled when high
- a_in  input  WIDTH  operand A (unsigned or two's complement)
- b_in  input  WIDTH  operand B
- control_in  input  1  0 = add (A+B), 1 = subtract (A−B)
- sum_out  output  WIDTH  registered result, modulo 2^WIDTH
- carry_out  output  1  registered carry-out of the MSB cell
- overflow_out  output  1  registered signed overflow
- zero_out  output  1  registered, high when the result is all zeros
- valid_out  output  1  registered copy of valid_in

## Operation
- Datapath: B' = b_in XOR {WIDTH{control_in}}. Carry-in to cell 0 = control_in.
- WIDTH full-adder cells in a ripple chain:
  - s[i] = a[i]^B'[i]^c[i]
  - c[i+1] = a[i]&B'[i] | c[i]&(a[i]^B'[i])
- Add: {carry, sum} = a_in + b_in. carry is the unsigned overflow.
- Subtract: sum = a_in − b_in mod 2^WIDTH. carry is the raw MSB carry of a + ~b + 1, so:
  - carry = 1 when a_in ≥ b_in (unsigned, no borrow)
  - carry = 0 when a borrow occurs
  - It is not inverted into a borrow flag.
- overflow = c[WIDTH] XOR c[WIDTH−1]. This is two's-complement overflow for both modes.
- zero = (sum == 0).
- Register update:
  - When valid_in = 1, on the rising clk edge, sum_out, carry_out, overflow_out and zero_out load the computed values.
  - When valid_in = 0, these four outputs hold their previous values.
  - valid_out loads valid_in on every edge.
- The combinational result is never exposed directly. All outputs come from flops.

## Timing
- Latency is 1 cycle. Operands sampled at edge N appear on the outputs after edge N, stable until the next accepted sample.
- Throughput is one operation per cycle. There is no back-pressure.
- Reset (rst_n low, asynchronous, with no clock needed) forces:
  - sum_out = 0
  - carry_out = 0
  - overflow_out = 0
  - zero_out = 0
  - valid_out = 0
- Reset dominates valid_in.
- Deassertion is synchronous to the design's clock domain. The first sample is taken at the first rising edge with rst_n high.
- Reset asserted mid-stream discards any pending result. There is no partial state.
- The control_in change and the operand change take effect at the same sample. There is no mode-switch penalty.
- Wrap-around (all bits of the sum) is ordinary modulo behaviour. There is no saturation.

## Test plan
1. Reset then add:
   - Assert rst_n = 0 with valid_in = 1, a = 7, b = 14; all outputs must be 0.
   - Release reset, add a = 7, b = 14 → next cycle sum = 5, carry = 1, overflow = 0, zero = 0, valid_out = 1.
2. Add sweep, one operation per cycle, each result checked one cycle later:
   - 0+0 → sum 0, carry 0, zero 1
   - 1+1 → 2, carry 0
   - 1+8 → 9, carry 0, overflow 0
   - 3+12 → 15, carry 0
   - 7+1 → 8, carry 0, overflow 1
3. Subtract sweep:
   - 15−15 → sum 0, carry 1, zero 1
   - 1−1 → 0, carry 1
   - 1−2 → 15, carry 0
   - 1−4 → 13, carry 0
   - 1−8 → 9, carry 0, overflow 1
   - 3−12 → 7, carry 0
   - 7−14 → 9, carry 0
4. Hold: after 1+1, drive valid_in = 0 with a = 15, b = 15, control = 1 for 3 cycles → sum stays 2, valid_out = 0; flags unchanged.
5. Async reset mid-stream: pulse rst_n low between clock edges while the result is 9 → outputs go to 0 immediately, without waiting for a clock edge. After release, the first valid sample of 3+12 → 15.
6. Exhaustive self-check (WIDTH = 4): all 512 combinations of a, b and control, back-to-back, compared against a behavioural (WIDTH+1)-bit reference with one-cycle delay; all flags must match.
